rf_wb_ctrl: RTL
===============

# rf_wb_ctrl

Write-back controller that is the writer side of the register file: it owns the RF write port (reg_write1, Rd, Bus_W) and feeds it from two producer streams, the ALU result and the load-data result. Each request is buffered in a small in-order FIFO and retired at one register write per cycle. Queued values are exposed through a two-port hazard/forwarding lookup so decode can bypass writes the RF has not yet absorbed.

## Interface
- DATA_W, 32, data width of register values
- ADDR_W, 4, register index width (16 registers)
- DEPTH, 4, FIFO entries (power of two, ≥2)

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- flush  in  1  synchronous: discard all queued entries
- a_valid / a_ready  in / out  1 / 1  ALU request handshake
- a_rd / a_data  in  ADDR_W / DATA_W  ALU destination and value
- b_valid / b_ready  in / out  1 / 1  load request handshake
- b_rd / b_data  in  ADDR_W / DATA_W  load destination and value
- reg_write1  out  1  RF write enable
- Rd  out  ADDR_W  RF write address
- Bus_W  out  DATA_W  RF write data
- reg_write2  out  1  tied 0; port 2 not driven by this block
- Bus_W1  out  DATA_W  tied 0
- chk_rs1, chk_rs2  in  ADDR_W  lookup indices
- chk_hit1, chk_hit2  out  1  index matches a queued entry
- fwd_data1, fwd_data2  out  DATA_W  value of youngest matching entry, 0 if no hit

## Operation
- Storage: DEPTH entries {rd, data}, head/tail pointers, count (0..DEPTH).
- Drain: whenever count≠0 the head is presented, reg_write1=1, Rd/Bus_W=head fields, and head pops at the next edge. There is no back-pressure from the RF.
- Free slots for acceptance: free = DEPTH − count + (count≠0 ? 1 : 0), so a push is allowed into a full FIFO that is popping in the same cycle.
- Acceptance:
  - free≥2: both ready, both streams can push in one cycle, b enqueued before a.
  - free==1: grant by round-robin bit rr (0 = b). Loser's ready=0. A lone valid requester is always granted.
  - free==0: both ready=0.
- a_ready and b_ready depend on count, rr and the other stream's valid only. They never depend on the same stream's valid.
- rr toggles only on a free==1 cycle where both were valid and one was granted.
- Lookup is combinational over all valid entries, including the head being written this cycle. On multiple matches the youngest entry wins. Rd=0 gets no special treatment.
- flush: count, head and tail go to 0 at the edge. Requests presented in the flush cycle are not accepted (ready=0 while flush=1). The head presented in that cycle is still written.

## Timing
- Reset values: count=0, pointers=0, rr=0, reg_write1=0, Rd=0, Bus_W=0, chk_hit*=0, fwd_data*=0. With an empty FIFO, a_ready=b_ready=1.
- Latency: request accepted at edge N → reg_write1 high in cycle N..N+1 → RF captures it at edge N+1.
- Forwarding: chk_hit for that register is visible from edge N until edge N+1.
- Throughput: one retirement per cycle. Sustained dual-stream input saturates the FIFO, then alternates grants.
- Reset asserted mid-operation clears all state immediately (asynchronously). Pending entries are lost.
- Rd, Bus_W and reg_write1 come straight from registered state or pointer muxes. They do not depend combinationally on any input.

## Structure
- Shared package: DATA_W/ADDR_W constants and wb_entry_t {rd, data}. The RF uses the same package.
- One sub-module, wb_fifo: storage, pointers, count, dual push, single pop, plus per-entry valid/rd/data outputs for the lookup.
- Arbitration and lookup live in rf_wb_ctrl.

## Test plan
- After reset: reg_write1=0, both ready=1. a pushes rd=1, data=0x12345678 at edge N → reg_write1=1, Rd=1, Bus_W=0x12345678 in the next cycle. chk_rs1=1 gives hit with fwd 0x12345678 in that cycle and no hit after edge N+1.
- Same-cycle dual push, b{2,0xB}, a{3,0xA}, empty FIFO → RF writes R2=0xB, then R3=0xA, on consecutive cycles.
- Fill to DEPTH with both streams held valid → ready never violates the free count. With free==1, grants alternate b, a, b, a. No entry is lost or reordered; check against a scoreboard.
- Two queued writes to R5 (0x11 then 0x22) → chk_rs2=5 returns 0x22 until the younger entry retires. RF sees 0x11 then 0x22.
- flush with 3 entries queued → only the presented head is written. count=0 next cycle, reg_write1=0, all hits clear.
- rst_n asserted between clock edges with entries queued → outputs go to reset values immediately with no further RF writes. After release, a new request is accepted normally.

Source files
------------

// File: rtl/rf_wb_ctrl_pkg.sv
// Shared definitions for the register-file write side: value/index widths and
// the {rd, data} record carried from the producers to the RF write port.
package rf_wb_ctrl_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 4;

    typedef struct packed {
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

    // Round-robin owner of the last free slot.
    typedef enum logic {
        GRANT_B = 1'b0,
        GRANT_A = 1'b1
    } rr_e;

endpackage

// File: rtl/rf_wb_ctrl_fifo.sv
// In-order write-back queue: up to two pushes and one pop per cycle, plus an
// age-ordered view of every slot (index 0 = head/oldest) for hazard lookup.
module wb_fifo
    import rf_wb_ctrl_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_i,
    input  logic             push0_i,
    input  wb_entry_t        push0_entry_i,
    input  logic             push1_i,
    input  wb_entry_t        push1_entry_i,
    input  logic             pop_i,
    output logic [CNT_W-1:0] count_o,
    output logic [DEPTH-1:0] ent_valid_o,
    output wb_entry_t        ent_o [DEPTH]
);

    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    wb_entry_t        mem_q [DEPTH];

    always_comb begin
        head_d  = head_q + PTR_W'(pop_i);
        tail_d  = tail_q + PTR_W'(push0_i) + PTR_W'(push1_i);
        count_d = count_q + CNT_W'(push0_i) + CNT_W'(push1_i) - CNT_W'(pop_i);
        if (flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // NOTE: storage has no reset; every read is qualified by count, so stale
    // contents are never observed and the array can map to plain flops/LUTRAM.
    always_ff @(posedge clk) begin
        if (push0_i) mem_q[tail_q] <= push0_entry_i;
        if (push1_i) mem_q[tail_q + PTR_W'(push0_i)] <= push1_entry_i;
    end

    always_comb begin
        ent_valid_o = '0;
        for (int k = 0; k < DEPTH; k++) begin
            ent_o[k]       = mem_q[head_q + PTR_W'(k)];
            ent_valid_o[k] = (k < int'(count_q));
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/rf_wb_ctrl.sv
// Write-back controller owning RF write port 1: arbitrates the ALU (a) and
// load (b) streams into an in-order queue and forwards queued values to decode.
module rf_wb_ctrl #(
    parameter int DATA_W = rf_wb_ctrl_pkg::DATA_W,
    parameter int ADDR_W = rf_wb_ctrl_pkg::ADDR_W,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [ADDR_W-1:0] a_rd,
    input  logic [DATA_W-1:0] a_data,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [ADDR_W-1:0] b_rd,
    input  logic [DATA_W-1:0] b_data,
    output logic              reg_write1,
    output logic [ADDR_W-1:0] Rd,
    output logic [DATA_W-1:0] Bus_W,
    output logic              reg_write2,
    output logic [DATA_W-1:0] Bus_W1,
    input  logic [ADDR_W-1:0] chk_rs1,
    input  logic [ADDR_W-1:0] chk_rs2,
    output logic              chk_hit1,
    output logic              chk_hit2,
    output logic [DATA_W-1:0] fwd_data1,
    output logic [DATA_W-1:0] fwd_data2
);
    import rf_wb_ctrl_pkg::*;

    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [CNT_W-1:0] count;
    logic [DEPTH-1:0] ent_valid;
    wb_entry_t        ent [DEPTH];
    wb_entry_t        a_ent, b_ent;
    logic             pop, push_a, push_b;
    logic [CNT_W:0]   free;
    rr_e              rr_q, rr_d;

    // The head always retires this cycle, so its slot counts as free.
    assign pop  = (count != '0);
    assign free = (CNT_W+1)'(DEPTH) - {1'b0, count} + (CNT_W+1)'(pop);

    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        a_ready = 1'b0;
        b_ready = 1'b0;
        rr_d    = rr_q;
        if (!flush) begin
            if (free >= (CNT_W+1)'(2)) begin
                a_ready = 1'b1;
                b_ready = 1'b1;
            end else if (free == (CNT_W+1)'(1)) begin
                b_ready = !a_valid || (rr_q == GRANT_B);
                a_ready = !b_valid || (rr_q == GRANT_A);
                if (a_valid && b_valid) rr_d = (rr_q == GRANT_B) ? GRANT_A : GRANT_B;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rr_q <= GRANT_B;
        else        rr_q <= rr_d;
    end

    assign push_a = a_valid && a_ready;
    assign push_b = b_valid && b_ready;
    assign a_ent  = '{rd: a_rd, data: a_data};
    assign b_ent  = '{rd: b_rd, data: b_data};

    // b is older than a when both push together.
    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush_i      (flush),
        .push0_i      (push_a || push_b),
        .push0_entry_i(push_b ? b_ent : a_ent),
        .push1_i      (push_a && push_b),
        .push1_entry_i(a_ent),
        .pop_i        (pop),
        .count_o      (count),
        .ent_valid_o  (ent_valid),
        .ent_o        (ent)
    );

    assign reg_write1 = pop;
    assign Rd         = pop ? ent[0].rd : '0;
    assign Bus_W      = pop ? ent[0].data : '0;
    assign reg_write2 = 1'b0;
    assign Bus_W1     = '0;

    // Ascending age order: a later (younger) match overrides an earlier one.
    always_comb begin
        chk_hit1  = 1'b0;
        chk_hit2  = 1'b0;
        fwd_data1 = '0;
        fwd_data2 = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (ent_valid[k] && ent[k].rd == chk_rs1) begin
                chk_hit1  = 1'b1;
                fwd_data1 = ent[k].data;
            end
            if (ent_valid[k] && ent[k].rd == chk_rs2) begin
                chk_hit2  = 1'b1;
                fwd_data2 = ent[k].data;
            end
        end
    end

endmodule
